ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that uses an external true dual-port RAM as its storage.
- RAM port A is used for writes only; RAM port B is used for reads only.
- The RAM has a 1-cycle registered read latency. The controller hides it behind a 2-entry first-word-fall-through output buffer, so the downstream side sees plain valid/ready at full throughput.
- Sits directly upstream of the RAM: it drives all RAM port signals and consumes the RAM's port-B read data.

Parameters:
- DATA_WIDTH, 32, word width; must match the attached RAM.
- ADDR_WIDTH, 10, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock for the controller and both RAM ports
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush; discards all contents
- s_valid  in  1  upstream word valid
- s_ready  out  1  controller can accept a word
- s_data  in  DATA_WIDTH  upstream word
- m_valid  out  1  head word valid
- m_ready  in  1  downstream accepts the head word
- m_data  out  DATA_WIDTH  head word
- level  out  ADDR_WIDTH+2  total words held
- ram_ena  out  1  RAM port-A enable
- ram_wea  out  1  RAM port-A write enable
- ram_addra  out  ADDR_WIDTH  RAM port-A address
- ram_dina  out  DATA_WIDTH  RAM port-A write data
- ram_enb  out  1  RAM port-B enable
- ram_web  out  1  RAM port-B write enable; tied 0
- ram_addrb  out  ADDR_WIDTH  RAM port-B address
- ram_doutb  in  DATA_WIDTH  RAM port-B read data; valid 1 cycle after a read is issued

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr, rd_ptr, ram_cnt, buf_cnt and inflight all 0.
  - Outputs while in reset: m_valid=0, s_ready=0, level=0, ram_ena/ram_enb=0.
  - s_ready rises on the first clk edge after rst_n is released. RAM contents are not cleared.
- Accepting words: push = s_valid & s_ready, where s_ready = (ram_cnt < DEPTH) & ~clr.
  - On a push: ram_ena = ram_wea = 1, ram_addra = wr_ptr, ram_dina = s_data; all combinational.
  - wr_ptr increments and wraps modulo DEPTH.
- Buffer occupancy: occ = buf_cnt + inflight, which never exceeds 2.
- Popping: pop = m_valid & m_ready.
- Issuing RAM reads: issue = (ram_cnt != 0) & ((occ - pop) < 2) & ~clr.
  - On an issue: ram_enb = 1, ram_addrb = rd_ptr. rd_ptr increments and wraps; inflight is set to 1 for the next cycle.
- Read data return: the cycle after an issue, ram_doutb is pushed into the 2-entry output buffer.
- ram_cnt next value = ram_cnt + push - issue. A push and an issue in the same cycle are both legal.
- No read/write address collision: a read is issued only for a word written in an earlier cycle.
- Output buffer: m_valid = (buf_cnt != 0); m_data = buffer head.
  - A pop and a return in the same cycle keeps buf_cnt unchanged and preserves order.
- Latency: a word pushed in cycle T into an empty FIFO gives m_valid=1 in cycle T+2.
  - T+1: read issued. T+2: word in buffer.
- Throughput: 1 word per cycle sustained when m_ready=1.
- Capacity: DEPTH+2 words (RAM plus the 2 buffer entries).
  - With m_ready=0, s_ready drops after DEPTH+2 accepted words.
- level = ram_cnt + buf_cnt + inflight, registered/consistent on every cycle.
- clr (synchronous): next cycle, pointers, counts and inflight are 0 and m_valid=0.
  - A read in flight at clr has its returning ram_doutb discarded.
  - A push or issue in the clr cycle is blocked.
  - clr overrides simultaneous pop/push.
- Pop when m_valid=0 is ignored. Push when s_ready=0 is ignored; the upstream must hold s_data.

Decomposition:
- Package ram_fifo_pkg:
  - Localparams DEPTH = 1<<ADDR_WIDTH and OBUF_DEPTH = 2.
  - Helper for level width (ADDR_WIDTH+2).
- One sub-module: fwft_obuf, the 2-entry register FIFO (push/pop/count/head).
- The pointer/count logic stays in the top module.

Test Plan:
- Reset: hold rst_n=0 while driving s_valid=1 -> s_ready=0, m_valid=0, level=0, ram_ena=0. First edge after release -> s_ready=1.
- Single word: push 0xA5A5_0001 at cycle T with m_ready=1 -> ram_addra=0 at T, ram_enb=1/ram_addrb=0 at T+1, m_valid=1 with m_data=0xA5A5_0001 at T+2, level returns to 0 after the pop.
- Fill (ADDR_WIDTH=2, DEPTH=4), m_ready=0: push 1..6 -> s_ready=0 after 6 accepts, level=6. Then m_ready=1 -> pops 1..6 in order, level=0.
- Streaming: s_valid=1 and m_ready=1 continuously, data 0..99 -> output 0..99 in order, one per cycle after 2-cycle fill, no bubbles; wr_ptr/rd_ptr wrap with ADDR_WIDTH=2.
- Random backpressure: random m_ready and s_valid, 1000 words -> scoreboard order match; level equals the model every cycle; never more than DEPTH+2 held.
- Flush mid-flight: push 3 words, assert clr in the cycle after a read issue -> next cycle level=0, m_valid=0, returning ram_doutb dropped. A new word 0x55 pushed afterward is the first word out.

Source files
------------

// File: rtl/ram_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_pkg
//  Description : Shared constants and sizing helpers for the RAM-backed FIFO
//                controller and its output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;

    // Output buffer entries that hide the one-cycle RAM read latency
    localparam int OBUF_DEPTH = 2;

    typedef logic [1:0] obuf_cnt_t;

    // RAM depth for a given address width
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Width needed to count DEPTH + OBUF_DEPTH words
    function automatic int level_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl_if
//  Description : Stream, flush, level and RAM-port signals of the RAM-backed
//                FIFO controller. slave = controller side, master = the
//                environment (upstream, downstream and the attached RAM).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_fifo_ctrl_if
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                                clr;
    logic                                s_valid;
    logic                                s_ready;
    logic [DATA_WIDTH-1:0]               s_data;
    logic                                m_valid;
    logic                                m_ready;
    logic [DATA_WIDTH-1:0]               m_data;
    logic [level_width(ADDR_WIDTH)-1:0]  level;
    logic                                ram_ena;
    logic                                ram_wea;
    logic [ADDR_WIDTH-1:0]               ram_addra;
    logic [DATA_WIDTH-1:0]               ram_dina;
    logic                                ram_enb;
    logic                                ram_web;
    logic [ADDR_WIDTH-1:0]               ram_addrb;
    logic [DATA_WIDTH-1:0]               ram_doutb;

    modport slave (
        input  clr, s_valid, s_data, m_ready, ram_doutb,
        output s_ready, m_valid, m_data, level,
               ram_ena, ram_wea, ram_addra, ram_dina,
               ram_enb, ram_web, ram_addrb
    );

    modport master (
        output clr, s_valid, s_data, m_ready, ram_doutb,
        input  s_ready, m_valid, m_data, level,
               ram_ena, ram_wea, ram_addra, ram_dina,
               ram_enb, ram_web, ram_addrb
    );
endinterface
`default_nettype wire

// File: rtl/ram_fifo_ctrl_fwft_obuf.sv
`default_nettype none
// ============================================================================
//  Module      : fwft_obuf
//  Description : Two-entry first-word-fall-through register FIFO. A word
//                arriving on in_valid is visible at the head in its arrival
//                cycle when the buffer is empty, so a RAM read issued in cycle
//                N is presentable downstream in cycle N+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwft_obuf
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  clr,
    input  wire logic                  in_valid,
    input  wire logic [DATA_WIDTH-1:0] in_data,
    input  wire logic                  pop,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output obuf_cnt_t                  count
);
    logic [DATA_WIDTH-1:0] r_mem [OBUF_DEPTH];
    logic                  r_wp;
    logic                  r_rp;
    obuf_cnt_t             r_count;
    logic                  w_wr;
    logic                  w_rd;

    // Arriving word is always written at the tail; when the buffer is empty
    // and it is popped in the same cycle both pointers advance together,
    // which leaves the buffer empty and keeps ordering trivially correct.
    assign w_wr      = in_valid & ~clr;
    assign w_rd      = pop & out_valid & ~clr;
    assign out_valid = (r_count != 2'd0) | in_valid;
    assign out_data  = (r_count != 2'd0) ? r_mem[r_rp] : in_data;
    assign count     = r_count;

    // Entry storage, no reset needed since the count qualifies it
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; clr empties the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= '0;
        end else if (clr) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= '0;
        end else begin
            r_wp    <= r_wp ^ w_wr;
            r_rp    <= r_rp ^ w_rd;
            r_count <= r_count + obuf_cnt_t'(w_wr) - obuf_cnt_t'(w_rd);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl
//  Description : FIFO controller using an external dual-port RAM (port A
//                write, port B read, 1-cycle read latency) with a 2-entry
//                FWFT output buffer for full-throughput valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    ram_fifo_ctrl_if.slave   bus
);
    localparam int                  DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam int                  LW        = level_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic                  r_inflight;
    logic                  r_run;
    obuf_cnt_t             w_buf_cnt;
    obuf_cnt_t             w_occ;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_s_ready;
    logic                  w_m_valid;
    logic [DATA_WIDTH-1:0] w_m_data;

    // r_run holds s_ready low during reset and for the release cycle
    assign w_s_ready = r_run & (r_ram_cnt < DEPTH_CNT) & ~bus.clr;
    assign w_push    = bus.s_valid & w_s_ready;
    assign w_pop     = w_m_valid & bus.m_ready;

    // A word in flight is already counted as buffer occupancy, so reads are
    // only issued when the buffer will still have room on return. Words
    // counted in r_ram_cnt were written in an earlier cycle, which rules
    // out a same-address read/write collision.
    assign w_occ   = w_buf_cnt + obuf_cnt_t'(r_inflight);
    assign w_issue = (r_ram_cnt != '0) & ((w_occ - obuf_cnt_t'(w_pop)) < 2'd2) & ~bus.clr;

    // Pointers, RAM word count and the in-flight flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (bus.clr) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_ram_cnt  <= '0;
                r_inflight <= 1'b0;
            end else begin
                r_wr_ptr   <= r_wr_ptr + ADDR_WIDTH'(w_push);
                r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(w_issue);
                r_ram_cnt  <= r_ram_cnt + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_issue);
                r_inflight <= w_issue;
            end
        end
    end

    fwft_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (bus.clr),
        .in_valid  (r_inflight),
        .in_data   (bus.ram_doutb),
        .pop       (w_pop),
        .out_valid (w_m_valid),
        .out_data  (w_m_data),
        .count     (w_buf_cnt)
    );

    assign bus.s_ready   = w_s_ready;
    assign bus.m_valid   = w_m_valid;
    assign bus.m_data    = w_m_data;
    assign bus.level     = LW'(r_ram_cnt) + LW'(w_buf_cnt) + LW'(r_inflight);

    assign bus.ram_ena   = w_push;
    assign bus.ram_wea   = w_push;
    assign bus.ram_addra = r_wr_ptr;
    assign bus.ram_dina  = bus.s_data;
    assign bus.ram_enb   = w_issue;
    assign bus.ram_web   = 1'b0;
    assign bus.ram_addrb = r_rd_ptr;
endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_fifo_ctrl
//  Description : Self-checking bench for ram_fifo_ctrl with a small RAM model
//                (ADDR_WIDTH=2) and a queue-based reference of held words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    ent_t q[$];
    logic [DW-1:0] ram [DEPTH];

    ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with registered read
    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wea) ram[bus.ram_addra] <= bus.ram_dina;
        if (bus.ram_enb) bus.ram_doutb <= ram[bus.ram_addrb];
    end

    // The oldest held word is presentable two cycles after it was accepted
    function automatic bit exp_mvalid();
        return (q.size() != 0) && (q[0].t + 2 <= cyc);
    endfunction

    // Update the reference with this cycle's handshakes, then move to the next cycle
    task automatic advance();
        bit push_now;
        bit pop_now;
        push_now = bus.s_valid && bus.s_ready;
        pop_now  = exp_mvalid() && bus.m_ready && !bus.clr;
        if (bus.clr) q.delete();
        else begin
            if (pop_now) q.delete(0);
            if (push_now) q.push_back('{d: bus.s_data, t: cyc});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.clr = 1'b0; bus.s_valid = 1'b1; bus.s_data = 32'hDEAD_BEEF; bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", bus.s_ready); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
        checks++; if (bus.level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
        checks++; if (bus.ram_ena !== 1'b0 || bus.ram_enb !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b%b want 00", bus.ram_ena, bus.ram_enb); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL release_s_ready got %b want 0", bus.s_ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL first_edge_s_ready got %b want 1", bus.s_ready); end
        bus.s_valid = 1'b0;
        q.delete();
        cyc = 0;
    endtask

    task automatic test_single();
        bus.s_valid = 1'b1; bus.s_data = 32'hA5A5_0001; bus.m_ready = 1'b1;
        #4;
        checks++; if (bus.ram_ena !== 1'b1 || bus.ram_wea !== 1'b1 || bus.ram_addra !== 2'd0 || bus.ram_dina !== 32'hA5A5_0001) begin
            errors++; $display("FAIL single_write got en=%b we=%b a=%0d d=%h want 1 1 0 a5a50001", bus.ram_ena, bus.ram_wea, bus.ram_addra, bus.ram_dina); end
        advance();
        bus.s_valid = 1'b0;
        #4;
        checks++; if (bus.ram_enb !== 1'b1 || bus.ram_addrb !== 2'd0) begin errors++; $display("FAIL single_issue got enb=%b addrb=%0d want 1 0", bus.ram_enb, bus.ram_addrb); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", bus.m_valid); end
        advance();
        #4;
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_out got v=%b d=%h want 1 a5a50001", bus.m_valid, bus.m_data); end
        checks++; if (bus.level !== 4'd1) begin errors++; $display("FAIL single_level got %0d want 1", bus.level); end
        advance();
        #4;
        checks++; if (bus.level !== 4'd0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_drain got lvl=%0d v=%b want 0 0", bus.level, bus.m_valid); end
        advance();
    endtask

    task automatic test_fill();
        int k = 1;
        int got = 0;
        bus.m_ready = 1'b0; bus.s_valid = 1'b1;
        for (int i = 0; i < 20 && k <= 6; i++) begin
            bus.s_data = DW'(k);
            #4;
            checks++; if (int'(bus.level) !== q.size()) begin errors++; $display("FAIL fill_level got %0d want %0d", bus.level, q.size()); end
            if (bus.s_ready) k++;
            advance();
        end
        bus.s_data = 32'd7;
        #4;
        checks++; if (k != 7) begin errors++; $display("FAIL fill_accepts got %0d want 6", k - 1); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL fill_full_s_ready got %b want 0", bus.s_ready); end
        checks++; if (bus.level !== 4'd6) begin errors++; $display("FAIL fill_full_level got %0d want 6", bus.level); end
        advance();
        bus.s_valid = 1'b0; bus.m_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() != 0; i++) begin
            #4;
            checks++; if (bus.m_valid !== exp_mvalid()) begin errors++; $display("FAIL fill_drain_valid got %b want %b", bus.m_valid, exp_mvalid()); end
            if (exp_mvalid()) begin
                got++;
                checks++; if (bus.m_data !== DW'(got)) begin errors++; $display("FAIL fill_drain_data got %0d want %0d", bus.m_data, got); end
            end
            advance();
        end
        #4;
        checks++; if (got != 6 || bus.level !== 4'd0) begin errors++; $display("FAIL fill_drain_end got pops=%0d lvl=%0d want 6 0", got, bus.level); end
        advance();
    endtask

    task automatic test_stream();
        int n_in = 0;
        int n_out = 0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 110; i++) begin
            bus.s_valid = (n_in < 100);
            bus.s_data  = DW'(n_in);
            #4;
            checks++; if (bus.m_valid !== exp_mvalid()) begin errors++; $display("FAIL stream_valid cyc %0d got %b want %b", i, bus.m_valid, exp_mvalid()); end
            if (i >= 2 && i < 102) begin
                checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL stream_bubble cyc %0d got %b want 1", i, bus.m_valid); end
            end
            if (bus.m_valid && exp_mvalid()) begin
                checks++; if (bus.m_data !== DW'(n_out)) begin errors++; $display("FAIL stream_data got %0d want %0d", bus.m_data, n_out); end
                n_out++;
            end
            if (bus.s_valid && bus.s_ready) n_in++;
            advance();
        end
        bus.s_valid = 1'b0;
        checks++; if (n_out != 100) begin errors++; $display("FAIL stream_count got %0d want 100", n_out); end
    endtask

    task automatic test_random();
        int sent = 0;
        int recv = 0;
        int i = 0;
        logic [DW-1:0] exp_d;
        bus.s_data = $urandom;
        while ((sent < 1000 || q.size() != 0) && i < 20000) begin
            bus.s_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            bus.m_ready = ($urandom_range(0, 9) < 6);
            #4;
            checks++; if (bus.m_valid !== exp_mvalid()) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", i, bus.m_valid, exp_mvalid()); end
            if (bus.m_valid && exp_mvalid()) begin
                exp_d = q[0].d;
                checks++; if (bus.m_data !== exp_d) begin errors++; $display("FAIL rand_data got %h want %h", bus.m_data, exp_d); end
            end
            checks++; if (int'(bus.level) !== q.size()) begin errors++; $display("FAIL rand_level got %0d want %0d", bus.level, q.size()); end
            checks++; if (int'(bus.level) > DEPTH + 2) begin errors++; $display("FAIL rand_capacity got %0d want <=%0d", bus.level, DEPTH + 2); end
            if (q.size() < DEPTH) begin
                checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rand_s_ready got %b want 1 at level %0d", bus.s_ready, q.size()); end
            end else if (q.size() == DEPTH + 2) begin
                checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rand_full got %b want 0", bus.s_ready); end
            end
            checks++; if (bus.ram_web !== 1'b0 || bus.ram_ena !== (bus.s_valid & bus.s_ready)) begin
                errors++; $display("FAIL rand_ram_ports got web=%b ena=%b want 0 %b", bus.ram_web, bus.ram_ena, bus.s_valid & bus.s_ready); end
            if (bus.m_ready && exp_mvalid()) recv++;
            if (bus.s_valid && bus.s_ready) begin
                sent++;
                advance();
                bus.s_data = $urandom;
            end else begin
                advance();
            end
            i++;
        end
        bus.s_valid = 1'b0;
        checks++; if (recv != 1000) begin errors++; $display("FAIL rand_done got %0d words in %0d cycles want 1000", recv, i); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] words [3];
        bit seen = 1'b0;
        words[0] = 32'h111; words[1] = 32'h222; words[2] = 32'h333;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1; bus.s_data = words[i];
            #4;
            checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL flush_push%0d got %b want 1", i, bus.s_ready); end
            advance();
        end
        bus.clr = 1'b1; bus.s_data = 32'h444; bus.m_ready = 1'b1;
        #4;
        checks++; if (bus.s_ready !== 1'b0 || bus.ram_ena !== 1'b0 || bus.ram_enb !== 1'b0) begin
            errors++; $display("FAIL flush_block got rdy=%b ena=%b enb=%b want 0 0 0", bus.s_ready, bus.ram_ena, bus.ram_enb); end
        advance();
        bus.clr = 1'b0; bus.s_valid = 1'b0;
        #4;
        checks++; if (bus.level !== 4'd0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got lvl=%0d v=%b want 0 0", bus.level, bus.m_valid); end
        advance();
        #4;
        checks++; if (bus.level !== 4'd0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got lvl=%0d v=%b want 0 0", bus.level, bus.m_valid); end
        bus.s_valid = 1'b1; bus.s_data = 32'h55;
        advance();
        bus.s_valid = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            #4;
            checks++; if (bus.m_valid !== exp_mvalid()) begin errors++; $display("FAIL flush_new_valid got %b want %b", bus.m_valid, exp_mvalid()); end
            if (bus.m_valid) begin
                seen = 1'b1;
                checks++; if (bus.m_data !== 32'h55) begin errors++; $display("FAIL flush_first_word got %h want 55", bus.m_data); end
            end
            advance();
        end
        checks++; if (!seen) begin errors++; $display("FAIL flush_timeout got no word want 55"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
